// File: rtl/axil_master_pkg.sv
// Shared types for the stream-to-AXI-lite master bridge: FSM states, response codes, index mapping.
// No timing of its own; backpressure is not applicable.
package axil_master_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_WRITE_RESP,
        ST_READ_ADDR,
        ST_READ_DATA,
        ST_READ_OUT
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'd0;
    localparam logic [1:0] RESP_EXOKAY = 2'd1;
    localparam logic [1:0] RESP_SLVERR = 2'd2;
    localparam logic [1:0] RESP_DECERR = 2'd3;

    // Registers are word-spaced; the caller truncates to its own address width.
    function automatic logic [63:0] index_to_addr(input logic [63:0] base, input logic [63:0] index);
        return base + (index << 2);
    endfunction

endpackage

// File: rtl/axil_master_arbiter.sv
// Round-robin pick between pending write and read requests; write wins first after reset.
// Combinational grant, zero latency; history only advances when the grant is actually taken.
module axil_master_arbiter (
    input  logic clock,
    input  logic reset,
    input  logic wr_req,
    input  logic rd_req,
    input  logic accept,
    output logic grant_wr,
    output logic grant_rd
);

    logic last_was_write;

    always_comb begin
        grant_wr = 1'b0;
        grant_rd = 1'b0;
        if (wr_req && rd_req) begin
            grant_wr = !last_was_write;
            grant_rd = last_was_write;
        end else begin
            grant_wr = wr_req;
            grant_rd = rd_req;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            last_was_write <= 1'b0;
        end else if (accept) begin
            last_was_write <= grant_wr;
        end
    end

endmodule

// File: rtl/axil_external_registers_master_cu.sv
// Bridges register write/read request streams onto a single-outstanding AXI-lite master port.
// Write 3 cycles / read 3 cycles to result with a zero-wait slave; read results wait on read_data_rdy without loss.
module axil_external_registers_master_cu
    import axil_master_pkg::*;
#(
    parameter int                    ADDR_WIDTH   = 32,
    parameter int                    DATA_WIDTH   = 32,
    parameter int                    DEST_WIDTH   = 8,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDRESS = '0
) (
    input  logic                      clock,
    input  logic                      reset,

    input  logic [DATA_WIDTH-1:0]     write_data_dat,
    input  logic [DEST_WIDTH-1:0]     write_data_dest,
    input  logic                      write_data_vld,
    output logic                      write_data_rdy,

    input  logic [DEST_WIDTH-1:0]     read_address_dat,
    input  logic                      read_address_vld,
    output logic                      read_address_rdy,

    output logic [DATA_WIDTH-1:0]     read_data_dat,
    output logic [DEST_WIDTH-1:0]     read_data_dest,
    output logic [1:0]                read_data_user,
    output logic                      read_data_vld,
    input  logic                      read_data_rdy,

    output logic [ADDR_WIDTH-1:0]     axi_out_awaddr,
    output logic [2:0]                axi_out_awprot,
    output logic                      axi_out_awvalid,
    input  logic                      axi_out_awready,
    output logic [DATA_WIDTH-1:0]     axi_out_wdata,
    output logic [DATA_WIDTH/8-1:0]   axi_out_wstrb,
    output logic                      axi_out_wvalid,
    input  logic                      axi_out_wready,
    input  logic [1:0]                axi_out_bresp,
    input  logic                      axi_out_bvalid,
    output logic                      axi_out_bready,
    output logic [ADDR_WIDTH-1:0]     axi_out_araddr,
    output logic [2:0]                axi_out_arprot,
    output logic                      axi_out_arvalid,
    input  logic                      axi_out_arready,
    input  logic [DATA_WIDTH-1:0]     axi_out_rdata,
    input  logic [1:0]                axi_out_rresp,
    input  logic                      axi_out_rvalid,
    output logic                      axi_out_rready,

    output logic                      bus_error,
    output logic                      busy
);

    state_t state, state_nxt;

    logic                  grant_wr, grant_rd, accept;
    logic                  aw_done, w_done, aw_hs, w_hs;
    logic [DATA_WIDTH-1:0] wdat_q, rdata_q;
    logic [DEST_WIDTH-1:0] idx_q;
    logic [1:0]            rresp_q;
    logic [ADDR_WIDTH-1:0] reg_addr;

    axil_master_arbiter u_arbiter (
        .clock    (clock),
        .reset    (reset),
        .wr_req   (write_data_vld),
        .rd_req   (read_address_vld),
        .accept   (accept),
        .grant_wr (grant_wr),
        .grant_rd (grant_rd)
    );

    assign accept = write_data_rdy | read_address_rdy;
    assign aw_hs  = axi_out_awvalid & axi_out_awready;
    assign w_hs   = axi_out_wvalid & axi_out_wready;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (grant_wr) begin
                    state_nxt = ST_WRITE;
                end else if (grant_rd) begin
                    state_nxt = ST_READ_ADDR;
                end
            end
            ST_WRITE: begin
                if ((aw_done || aw_hs) && (w_done || w_hs)) begin
                    state_nxt = ST_WRITE_RESP;
                end
            end
            ST_WRITE_RESP: if (axi_out_bvalid)  state_nxt = ST_IDLE;
            ST_READ_ADDR:  if (axi_out_arready) state_nxt = ST_READ_DATA;
            ST_READ_DATA:  if (axi_out_rvalid)  state_nxt = ST_READ_OUT;
            ST_READ_OUT:   if (read_data_rdy)   state_nxt = ST_IDLE;
            default:       state_nxt = ST_IDLE;
        endcase
    end

    // Readies are masked by reset so nothing is taken while the bridge is being cleared.
    always_comb begin
        write_data_rdy   = 1'b0;
        read_address_rdy = 1'b0;
        axi_out_awvalid  = 1'b0;
        axi_out_wvalid   = 1'b0;
        axi_out_bready   = 1'b0;
        axi_out_arvalid  = 1'b0;
        axi_out_rready   = 1'b0;
        read_data_vld    = 1'b0;
        case (state)
            ST_IDLE: begin
                write_data_rdy   = grant_wr && !reset;
                read_address_rdy = grant_rd && !reset;
            end
            ST_WRITE: begin
                axi_out_awvalid = !aw_done;
                axi_out_wvalid  = !w_done;
            end
            ST_WRITE_RESP: axi_out_bready  = 1'b1;
            ST_READ_ADDR:  axi_out_arvalid = 1'b1;
            ST_READ_DATA:  axi_out_rready  = 1'b1;
            ST_READ_OUT:   read_data_vld   = 1'b1;
            default: ;
        endcase
    end

    assign busy = (state != ST_IDLE);

    always_ff @(posedge clock) begin
        if (reset) begin
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
            wdat_q    <= '0;
            idx_q     <= '0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
            bus_error <= 1'b0;
        end else begin
            if (write_data_rdy) begin
                wdat_q  <= write_data_dat;
                idx_q   <= write_data_dest;
                aw_done <= 1'b0;
                w_done  <= 1'b0;
            end
            if (read_address_rdy) begin
                idx_q <= read_address_dat;
            end
            if (aw_hs) begin
                aw_done <= 1'b1;
            end
            if (w_hs) begin
                w_done <= 1'b1;
            end
            if (axi_out_bvalid && axi_out_bready && axi_out_bresp != RESP_OKAY) begin
                bus_error <= 1'b1;
            end
            if (axi_out_rvalid && axi_out_rready) begin
                rdata_q <= axi_out_rdata;
                rresp_q <= axi_out_rresp;
                if (axi_out_rresp != RESP_OKAY) begin
                    bus_error <= 1'b1;
                end
            end
        end
    end

    assign reg_addr       = ADDR_WIDTH'(index_to_addr(64'(BASE_ADDRESS), 64'(idx_q)));
    assign axi_out_awaddr = reg_addr;
    assign axi_out_araddr = reg_addr;
    assign axi_out_awprot = 3'b000;
    assign axi_out_arprot = 3'b000;
    assign axi_out_wdata  = wdat_q;
    assign axi_out_wstrb  = '1;

    assign read_data_dat  = rdata_q;
    assign read_data_dest = idx_q;
    assign read_data_user = rresp_q;

endmodule

// File: tb/tb_axil_external_registers_master_cu.sv
// Directed bench for the stream-to-AXI-lite master bridge with a small AXI-lite slave model.
module tb_axil_external_registers_master_cu;

    localparam logic [31:0] BASE = 32'h43C0_0000;

    logic        clock, reset;
    logic [31:0] write_data_dat;
    logic [7:0]  write_data_dest;
    logic        write_data_vld, write_data_rdy;
    logic [7:0]  read_address_dat;
    logic        read_address_vld, read_address_rdy;
    logic [31:0] read_data_dat;
    logic [7:0]  read_data_dest;
    logic [1:0]  read_data_user;
    logic        read_data_vld, read_data_rdy;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [2:0]  awprot, arprot;
    logic [3:0]  wstrb;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [1:0]  bresp, rresp;
    logic        bus_error, busy;

    logic        aw_rdy_en, w_rdy_en, ar_rdy_en;
    logic [1:0]  bresp_knob, rresp_knob;

    int checks = 0;
    int errors = 0;

    axil_external_registers_master_cu #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .DEST_WIDTH(8), .BASE_ADDRESS(BASE)
    ) dut (
        .clock(clock), .reset(reset),
        .write_data_dat(write_data_dat), .write_data_dest(write_data_dest),
        .write_data_vld(write_data_vld), .write_data_rdy(write_data_rdy),
        .read_address_dat(read_address_dat), .read_address_vld(read_address_vld),
        .read_address_rdy(read_address_rdy),
        .read_data_dat(read_data_dat), .read_data_dest(read_data_dest),
        .read_data_user(read_data_user), .read_data_vld(read_data_vld),
        .read_data_rdy(read_data_rdy),
        .axi_out_awaddr(awaddr), .axi_out_awprot(awprot), .axi_out_awvalid(awvalid),
        .axi_out_awready(awready), .axi_out_wdata(wdata), .axi_out_wstrb(wstrb),
        .axi_out_wvalid(wvalid), .axi_out_wready(wready), .axi_out_bresp(bresp),
        .axi_out_bvalid(bvalid), .axi_out_bready(bready), .axi_out_araddr(araddr),
        .axi_out_arprot(arprot), .axi_out_arvalid(arvalid), .axi_out_arready(arready),
        .axi_out_rdata(rdata), .axi_out_rresp(rresp), .axi_out_rvalid(rvalid),
        .axi_out_rready(rready),
        .bus_error(bus_error), .busy(busy)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // ---------------- AXI-lite slave model and monitors ----------------
    assign awready = aw_rdy_en;
    assign wready  = w_rdy_en;
    assign arready = ar_rdy_en;
    assign bresp   = bresp_knob;
    assign rresp   = rresp_knob;

    logic        aw_hs, w_hs, ar_hs;
    assign aw_hs = awvalid && awready;
    assign w_hs  = wvalid && wready;
    assign ar_hs = arvalid && arready;

    logic [31:0] mem [0:255];
    bit          mem_loaded;
    logic        aw_got, w_got;
    logic [31:0] aw_addr_l, w_dat_l, last_waddr, last_wdata;
    logic [3:0]  wstrb_l, last_wstrb;
    int aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, wr_acc = 0, rd_acc = 0, rd_cnt = 0;
    int order_n = 0;
    bit          order_log [0:63];
    logic [31:0] rd_log_dat  [0:63];
    logic [7:0]  rd_log_dest [0:63];

    function automatic logic [7:0] addr_idx(input logic [31:0] a);
        logic [31:0] o;
        o = a - BASE;
        return o[9:2];
    endfunction

    function automatic logic [31:0] preload(input int i);
        return (i == 1) ? 32'h1234_5678 : (32'hA500_0000 | 32'(i));
    endfunction

    always @(posedge clock) begin
        if (!mem_loaded) begin
            for (int i = 0; i < 256; i++) mem[i] <= preload(i);
            mem_loaded <= 1'b1;
        end
        if (reset) begin
            bvalid <= 1'b0;
            rvalid <= 1'b0;
            aw_got <= 1'b0;
            w_got  <= 1'b0;
        end else begin
            if (aw_hs) aw_addr_l <= awaddr;
            if (w_hs) begin
                w_dat_l <= wdata;
                wstrb_l <= wstrb;
            end
            if ((aw_got || aw_hs) && (w_got || w_hs)) begin
                bvalid     <= 1'b1;
                aw_got     <= 1'b0;
                w_got      <= 1'b0;
                mem[addr_idx(aw_hs ? awaddr : aw_addr_l)] <= w_hs ? wdata : w_dat_l;
                last_waddr <= aw_hs ? awaddr : aw_addr_l;
                last_wdata <= w_hs ? wdata : w_dat_l;
                last_wstrb <= w_hs ? wstrb : wstrb_l;
            end else begin
                if (aw_hs) aw_got <= 1'b1;
                if (w_hs)  w_got  <= 1'b1;
            end
            if (bvalid && bready) bvalid <= 1'b0;
            if (ar_hs) begin
                rvalid <= 1'b1;
                rdata  <= mem[addr_idx(araddr)];
            end
            if (rvalid && rready) rvalid <= 1'b0;
        end
        if (aw_hs) begin
            aw_cnt <= aw_cnt + 1;
            order_log[order_n] <= 1'b0;
            order_n <= order_n + 1;
        end
        if (ar_hs) begin
            ar_cnt <= ar_cnt + 1;
            order_log[order_n] <= 1'b1;
            order_n <= order_n + 1;
        end
        if (w_hs) w_cnt <= w_cnt + 1;
        if (bvalid && bready) b_cnt <= b_cnt + 1;
        if (write_data_vld && write_data_rdy) wr_acc <= wr_acc + 1;
        if (read_address_vld && read_address_rdy) rd_acc <= rd_acc + 1;
        if (read_data_vld && read_data_rdy) begin
            rd_log_dat[rd_cnt]  <= read_data_dat;
            rd_log_dest[rd_cnt] <= read_data_dest;
            rd_cnt <= rd_cnt + 1;
        end
    end

    // ---------------- helpers ----------------
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_wr(input logic [31:0] d, input logic [7:0] dst);
        bit ok;
        ok = 1'b0;
        write_data_dat  = d;
        write_data_dest = dst;
        write_data_vld  = 1'b1;
        for (int i = 0; i < 100 && !ok; i++) begin
            #1 ok = write_data_rdy;
            @(posedge clock);
            #1;
        end
        write_data_vld = 1'b0;
        chk("wr_accept", 64'(ok), 64'd1);
    endtask

    task automatic send_rd(input logic [7:0] idx);
        bit ok;
        ok = 1'b0;
        read_address_dat = idx;
        read_address_vld = 1'b1;
        for (int i = 0; i < 100 && !ok; i++) begin
            #1 ok = read_address_rdy;
            @(posedge clock);
            #1;
        end
        read_address_vld = 1'b0;
        chk("rd_accept", 64'(ok), 64'd1);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 100 && busy; i++) begin
            @(posedge clock);
            #1;
        end
        chk("idle_timeout", 64'(busy), 64'd0);
    endtask

    task automatic expect_read(input logic [31:0] d, input logic [7:0] dst, input logic [1:0] u);
        for (int i = 0; i < 100 && !read_data_vld; i++) begin
            @(posedge clock);
            #1;
        end
        chk("rd_vld", 64'(read_data_vld), 64'd1);
        chk("rd_dat", 64'(read_data_dat), 64'(d));
        chk("rd_dest", 64'(read_data_dest), 64'(dst));
        chk("rd_user", 64'(read_data_user), 64'(u));
        @(posedge clock);
        #1;
    endtask

    // ---------------- directed sequence ----------------
    logic [31:0] wv [0:3];
    int wk, rk, ob, rb, c0, c1, c2, c3;
    bit wa, ra;

    initial begin
        wv[0] = 32'hCAFE_0010; wv[1] = 32'h0BAD_0011;
        wv[2] = 32'h600D_0012; wv[3] = 32'hFACE_0013;
        reset = 1'b1;
        write_data_vld = 0; write_data_dat = 0; write_data_dest = 0;
        read_address_vld = 0; read_address_dat = 0; read_data_rdy = 1'b1;
        aw_rdy_en = 1; w_rdy_en = 1; ar_rdy_en = 1; bresp_knob = 0; rresp_knob = 0;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_awvalid", 64'(awvalid), 0);
        chk("rst_wvalid", 64'(wvalid), 0);
        chk("rst_arvalid", 64'(arvalid), 0);
        chk("rst_bready", 64'(bready), 0);
        chk("rst_rready", 64'(rready), 0);
        chk("rst_rd_vld", 64'(read_data_vld), 0);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_bus_error", 64'(bus_error), 0);
        reset = 1'b0;
        @(posedge clock);
        #1;

        // Write-only at index 2
        send_wr(32'hDEAD_BEEF, 8'd2);
        chk("w_awvalid", 64'(awvalid), 1);
        chk("w_wvalid", 64'(wvalid), 1);
        chk("w_awaddr", 64'(awaddr), 64'h43C0_0008);
        chk("w_wdata", 64'(wdata), 64'hDEAD_BEEF);
        chk("w_wstrb", 64'(wstrb), 64'hF);
        chk("w_awprot", 64'(awprot), 0);
        @(posedge clock);
        #1;
        chk("w_resp_bready", 64'(bready), 1);
        chk("w_resp_awvalid", 64'(awvalid), 0);
        @(posedge clock);
        #1;
        chk("w_idle_latency", 64'(busy), 0);
        chk("w_b_cnt", 64'(b_cnt), 1);
        chk("w_aw_cnt", 64'(aw_cnt), 1);
        chk("w_slave_addr", 64'(last_waddr), 64'h43C0_0008);
        chk("w_slave_data", 64'(last_wdata), 64'hDEAD_BEEF);
        chk("w_slave_strb", 64'(last_wstrb), 64'hF);
        chk("w_bus_error", 64'(bus_error), 0);

        // Read-only at index 1
        send_rd(8'd1);
        chk("r_arvalid", 64'(arvalid), 1);
        chk("r_araddr", 64'(araddr), 64'h43C0_0004);
        chk("r_arprot", 64'(arprot), 0);
        @(posedge clock);
        #1;
        chk("r_rready", 64'(rready), 1);
        @(posedge clock);
        #1;
        chk("r_out_latency", 64'(read_data_vld), 1);
        expect_read(32'h1234_5678, 8'd1, 2'd0);
        chk("r_vld_drop", 64'(read_data_vld), 0);
        repeat (3) @(posedge clock);
        #1;
        chk("r_once", 64'(rd_cnt), 1);
        chk("r_idle", 64'(busy), 0);

        // Simultaneous requests: write/read to indices 10..13, alternate priority
        ob = order_n; rb = rd_cnt; c0 = b_cnt;
        wk = 0; rk = 0;
        write_data_dat = wv[0]; write_data_dest = 8'd10; write_data_vld = 1;
        read_address_dat = 8'd10; read_address_vld = 1;
        for (int c = 0; c < 400 && (wk < 4 || rk < 4); c++) begin
            #1;
            wa = write_data_vld && write_data_rdy;
            ra = read_address_vld && read_address_rdy;
            @(posedge clock);
            #1;
            if (wa) begin
                wk++;
                if (wk < 4) begin
                    write_data_dat = wv[wk]; write_data_dest = 8'(10 + wk);
                end else write_data_vld = 0;
            end
            if (ra) begin
                rk++;
                if (rk < 4) read_address_dat = 8'(10 + rk);
                else read_address_vld = 0;
            end
        end
        write_data_vld = 0; read_address_vld = 0;
        wait_idle();
        repeat (2) @(posedge clock);
        #1;
        chk("sim_wr_done", 64'(wk), 4);
        chk("sim_rd_done", 64'(rk), 4);
        chk("sim_b_cnt", 64'(b_cnt - c0), 4);
        for (int k = 0; k < 8; k++) chk("sim_order", 64'(order_log[ob + k]), 64'(k % 2));
        for (int k = 0; k < 4; k++) begin
            chk("sim_rd_dat", 64'(rd_log_dat[rb + k]), 64'(wv[k]));
            chk("sim_rd_dest", 64'(rd_log_dest[rb + k]), 64'(10 + k));
        end

        // AW completes 3 cycles before W
        c0 = b_cnt; c1 = aw_cnt; c2 = w_cnt; c3 = wr_acc;
        w_rdy_en = 0;
        send_wr(32'h5A5A_0001, 8'd4);
        chk("skA_aw_first", 64'(awvalid), 1);
        @(posedge clock);
        #1;
        chk("skA_aw_dropped", 64'(awvalid), 0);
        chk("skA_w_held", 64'(wvalid), 1);
        repeat (2) @(posedge clock);
        #1;
        chk("skA_w_still", 64'(wvalid), 1);
        chk("skA_wdata", 64'(wdata), 64'h5A5A_0001);
        w_rdy_en = 1;
        wait_idle();
        chk("skA_b_once", 64'(b_cnt - c0), 1);
        chk("skA_aw_once", 64'(aw_cnt - c1), 1);
        chk("skA_w_once", 64'(w_cnt - c2), 1);
        chk("skA_acc_once", 64'(wr_acc - c3), 1);
        chk("skA_mem", 64'(last_wdata), 64'h5A5A_0001);

        // W completes 3 cycles before AW
        c0 = b_cnt; c1 = aw_cnt; c2 = w_cnt; c3 = wr_acc;
        aw_rdy_en = 0;
        send_wr(32'hA5A5_0002, 8'd5);
        @(posedge clock);
        #1;
        chk("skB_w_dropped", 64'(wvalid), 0);
        chk("skB_aw_held", 64'(awvalid), 1);
        repeat (2) @(posedge clock);
        #1;
        chk("skB_aw_still", 64'(awvalid), 1);
        chk("skB_awaddr", 64'(awaddr), 64'h43C0_0014);
        aw_rdy_en = 1;
        wait_idle();
        chk("skB_b_once", 64'(b_cnt - c0), 1);
        chk("skB_aw_once", 64'(aw_cnt - c1), 1);
        chk("skB_w_once", 64'(w_cnt - c2), 1);
        chk("skB_acc_once", 64'(wr_acc - c3), 1);
        chk("skB_addr", 64'(last_waddr), 64'h43C0_0014);

        // Backpressure with SLVERR read response
        rresp_knob = 2'd2;
        read_data_rdy = 0;
        c0 = ar_cnt; c1 = rd_cnt; c2 = wr_acc; c3 = aw_cnt;
        send_rd(8'd3);
        repeat (2) @(posedge clock);
        #1;
        write_data_dat = 32'h0000_BEEF; write_data_dest = 8'd6; write_data_vld = 1;
        for (int i = 0; i < 10; i++) begin
            chk("bp_vld", 64'(read_data_vld), 1);
            chk("bp_dat", 64'(read_data_dat), 64'hA500_0003);
            chk("bp_user", 64'(read_data_user), 2);
            chk("bp_dest", 64'(read_data_dest), 3);
            @(posedge clock);
            #1;
        end
        chk("bp_bus_error", 64'(bus_error), 1);
        chk("bp_no_new_ar", 64'(ar_cnt - c0), 1);
        chk("bp_no_wr_acc", 64'(wr_acc - c2), 0);
        chk("bp_no_aw", 64'(aw_cnt - c3), 0);
        read_data_rdy = 1;
        @(posedge clock);
        #1;
        chk("bp_rd_once", 64'(rd_cnt - c1), 1);
        chk("bp_vld_drop", 64'(read_data_vld), 0);
        @(posedge clock);
        #1;
        write_data_vld = 0;
        rresp_knob = 2'd0;
        wait_idle();
        chk("bp_wr_after", 64'(wr_acc - c2), 1);
        chk("bp_err_sticky", 64'(bus_error), 1);

        // Reset while AWVALID is pending
        aw_rdy_en = 0;
        send_wr(32'h0000_0077, 8'd6);
        @(posedge clock);
        #1;
        chk("mr_aw_pending", 64'(awvalid), 1);
        chk("mr_busy_before", 64'(busy), 1);
        reset = 1;
        @(posedge clock);
        #1;
        chk("mr_awvalid", 64'(awvalid), 0);
        chk("mr_wvalid", 64'(wvalid), 0);
        chk("mr_arvalid", 64'(arvalid), 0);
        chk("mr_rd_vld", 64'(read_data_vld), 0);
        chk("mr_busy", 64'(busy), 0);
        chk("mr_bus_error", 64'(bus_error), 0);
        reset = 0;
        aw_rdy_en = 1;
        @(posedge clock);
        #1;
        c0 = b_cnt;
        send_wr(32'h0123_4567, 8'd7);
        wait_idle();
        chk("mr_b_after", 64'(b_cnt - c0), 1);
        send_rd(8'd7);
        expect_read(32'h0123_4567, 8'd7, 2'd0);
        wait_idle();
        chk("mr_err_after", 64'(bus_error), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
